shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Command sequencer that sits directly upstream of the 4-bit shift/rotate/load register and drives its control inputs (ENB, DIR, MODO, D, S_IN). It accepts one command per valid/ready handshake: load, N-step shift, N-step rotate, or load-then-shift. It issues the matching per-cycle register controls, then pulses DONE. The host sees a simple command interface; the register sees only legal, cycle-exact control.

## Interface
- CNT_W, 4: width of the step-count field; max steps per command = 2^CNT_W − 1.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept; high only in IDLE.
- CMD_OP  in  2  00 shift, 01 rotate, 10 load, 11 load-then-shift.
- CMD_DIR  in  1  0 left, 1 right.
- CMD_CNT  in  CNT_W  number of shift/rotate steps.
- CMD_DATA  in  4  parallel load value.
- CMD_SIN  in  1  serial fill bit for shift steps.
- ENB  out  1  register enable.
- DIR  out  1  register direction.
- MODO  out  2  register mode: 00 shift, 01 rotate, 10 load.
- D  out  4  register parallel data.
- S_IN  out  1  register serial input.
- BUSY  out  1  high in any state but IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- Command fields are captured into internal registers on the accepting edge (CMD_VALID && CMD_READY). Inputs are ignored at all other times.
- FSM states: IDLE, LOAD, SHIFT, FIN.
  - IDLE: on accept, go to LOAD if op is 10/11. Otherwise go to SHIFT if CNT ≠ 0, else FIN.
  - LOAD: ENB=1, MODO=10, D=captured data. Next state: SHIFT if op 11 and CNT ≠ 0, else FIN.
  - SHIFT: ENB=1, MODO=00 for op 00/11 or 01 for op 01. DIR and S_IN take the captured values. The remaining-step counter decrements each cycle; on the cycle it reads 1, the next state is FIN.
  - FIN: ENB=0, DONE=1, next state IDLE.
- The CMD_CNT field is ignored for op 10.
- Outputs are Moore: pure functions of registered state and captured fields. No combinational path exists from CMD_* to register controls.
- Outside LOAD/SHIFT: ENB=0, MODO=00, D=0, S_IN=0, DIR holds the last captured value.
- Reset values: state IDLE, ENB 0, DIR 0, MODO 00, D 0, S_IN 0, BUSY 0, DONE 0, CMD_READY 1 on the first cycle after reset.
- RST mid-command: the next edge forces IDLE with all outputs at reset values. The aborted command produces no DONE.
- CMD_VALID held high across FIN: the next command is accepted in the following IDLE cycle. Back-to-back throughput is one command per (steps + load + 2) cycles.

## Timing
- The command is accepted at edge k. The first ENB-high cycle is k+1 to k+2.
- Op 10: exactly 1 ENB cycle; DONE at k+2 to k+3.
- Op 00/01: exactly CNT ENB cycles, contiguous.
- Op 11: 1 load cycle plus CNT shift cycles, contiguous.
- DONE is asserted in the cycle after the last ENB cycle. With zero steps (op 00/01), DONE is asserted at k+1 to k+2.
- CMD_READY is low from k+1 until the cycle after DONE.

## Configuration
- SHIFT_SEQ_ABORT_EN defined:
  - Adds input ABORT (1 bit).
  - ABORT high in LOAD or SHIFT forces ENB=0 combinationally in that cycle; the next state is IDLE.
  - DONE is not pulsed. An output ABORTED pulses for one cycle, coincident with the first IDLE cycle.
  - ABORT is ignored in IDLE and FIN.
- Undefined: no ABORT/ABORTED ports; every accepted command runs to completion.

## Structure
- Shared package shift_seq_pkg: CMD_OP encodings, MODO encodings (00/01/10), and the FSM state enum (IDLE, LOAD, SHIFT, FIN).
- Sub-module shift_seq_step_cnt: loadable CNT_W-bit down-counter with load, decrement, and is_one/is_zero flags.

## Test plan
- Reset: RST high for 2 cycles, then low → CMD_READY=1, ENB=0, MODO=00, BUSY=0, DONE=0.
- Op 10, DATA=4'b1011 → one cycle with ENB=1, MODO=10, D=1011; DONE on the next cycle. A register model shows Q=1011.
- Op 11, DATA=4'b1000, DIR=1, SIN=0, CNT=3 → 1 load cycle plus 3 shift cycles with ENB high; register model Q=0001; DONE once.
- Op 01, DIR=0, CNT=0 → no ENB cycle; DONE at k+1; CMD_READY returns to 1 the next cycle.
- CMD_VALID held high with two rotate commands of CNT=2 and CNT=15 (CNT_W=4) → 2 then 15 contiguous ENB cycles, two DONE pulses, and no accept while BUSY.
- RST asserted during cycle 2 of a CNT=5 shift → IDLE next cycle, ENB=0, no DONE. With SHIFT_SEQ_ABORT_EN defined, repeat using ABORT instead → ENB low in the same cycle, ABORTED pulse, no DONE.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: command ops, register modes and FSM states.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SHIFT      = 2'b00,
        OP_ROTATE     = 2'b01,
        OP_LOAD       = 2'b10,
        OP_LOAD_SHIFT = 2'b11
    } cmd_op_e;

    localparam logic [1:0] MODO_SHIFT  = 2'b00;
    localparam logic [1:0] MODO_ROTATE = 2'b01;
    localparam logic [1:0] MODO_LOAD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_FIN   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/shift_seq_step_cnt.sv
// Loadable down-counter holding the remaining shift/rotate steps of the active command.
module shift_seq_step_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o,
    output logic             is_zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o  = (count_q == {{(CNT_W-1){1'b0}}, 1'b1});
    assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer driving the 4-bit shift/rotate/load register controls.
// Optional SHIFT_SEQ_ABORT_EN adds abort_i/aborted_o to cancel a running command.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic             cmd_dir_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
    input  logic [3:0]       cmd_data_i,
    input  logic             cmd_sin_i,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    output logic             enb_o,
    output logic             dir_o,
    output logic [1:0]       modo_o,
    output logic [3:0]       d_o,
    output logic             s_in_o,
    output logic             busy_o,
    output logic             done_o
);

    seq_state_e state_q, state_d;
    cmd_op_e    op_q;
    logic       dir_q;
    logic [3:0] data_q;
    logic       sin_q;
    logic       accept;
    logic       abortHit;
    logic       enbRaw;
    logic       cntOne;
    logic       cntZero;
    cmd_op_e    opIn;

    assign opIn   = cmd_op_e'(cmd_op_i);
    assign accept = cmd_valid_i && (state_q == ST_IDLE);

`ifdef SHIFT_SEQ_ABORT_EN
    logic aborted_q;
    assign abortHit = abort_i && ((state_q == ST_LOAD) || (state_q == ST_SHIFT));
    assign aborted_o = aborted_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abortHit;
        end
    end
`else
    assign abortHit = 1'b0;
`endif

    // A pure load never shifts, so its step field is forced to zero on capture.
    shift_seq_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i ((opIn == OP_LOAD) ? '0 : cmd_cnt_i),
        .dec_i      (state_q == ST_SHIFT),
        .is_one_o   (cntOne),
        .is_zero_o  (cntZero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SHIFT;
            dir_q   <= 1'b0;
            data_q  <= 4'b0000;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= opIn;
                dir_q  <= cmd_dir_i;
                data_q <= cmd_data_i;
                sin_q  <= cmd_sin_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        enbRaw  = 1'b0;
        modo_o  = MODO_SHIFT;
        d_o     = 4'b0000;
        s_in_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op_i[1]) begin
                        state_d = ST_LOAD;
                    end else if (cmd_cnt_i != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_LOAD: begin
                enbRaw  = 1'b1;
                modo_o  = MODO_LOAD;
                d_o     = data_q;
                state_d = ((op_q == OP_LOAD_SHIFT) && !cntZero) ? ST_SHIFT : ST_FIN;
            end
            ST_SHIFT: begin
                enbRaw = 1'b1;
                modo_o = (op_q == OP_ROTATE) ? MODO_ROTATE : MODO_SHIFT;
                s_in_o = sin_q;
                if (cntOne) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abortHit) begin
            state_d = ST_IDLE;
        end
    end

    assign enb_o       = enbRaw && !abortHit;
    assign dir_o       = dir_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign done_o      = (state_q == ST_FIN);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer; expected per-cycle controls are queued at issue time.
// Build with SHIFT_SEQ_ABORT_EN to exercise the abort path as well.
module tb_shift_sequencer;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       enb;
        logic [1:0] modo;
        logic [3:0] d;
        logic       dir;
        logic       sin;
        logic       done;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic       cmdDir;
    logic [3:0] cmdCnt;
    logic [3:0] cmdData;
    logic       cmdSin;
    logic       enb;
    logic       dir;
    logic [1:0] modo;
    logic [3:0] d;
    logic       sIn;
    logic       busy;
    logic       done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    obs_t expQ[$];
    int   compared;
    int   mismatched;
    logic [3:0] regQ;

    shift_sequencer #(.CNT_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_op_i    (cmdOp),
        .cmd_dir_i   (cmdDir),
        .cmd_cnt_i   (cmdCnt),
        .cmd_data_i  (cmdData),
        .cmd_sin_i   (cmdSin),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort_i     (abort),
        .aborted_o   (aborted),
`endif
        .enb_o       (enb),
        .dir_o       (dir),
        .modo_o      (modo),
        .d_o         (d),
        .s_in_o      (sIn),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the downstream 4-bit register fed by the sequencer's controls.
    always @(posedge clk) begin
        if (rst) begin
            regQ <= 4'b0000;
        end else if (enb) begin
            case (modo)
                2'b10: regQ <= d;
                2'b00: regQ <= dir ? {sIn, regQ[3:1]} : {regQ[2:0], sIn};
                2'b01: regQ <= dir ? {regQ[0], regQ[3:1]} : {regQ[2:0], regQ[3]};
                default: regQ <= regQ;
            endcase
        end
    end

    function automatic obs_t sample();
        obs_t o;
        o.ready = cmdReady;
        o.busy  = busy;
        o.enb   = enb;
        o.modo  = modo;
        o.d     = d;
        o.dir   = dir;
        o.sin   = sIn;
        o.done  = done;
        return o;
    endfunction

    task automatic pushIdle(input logic expDir);
        obs_t e;
        e = '0;
        e.ready = 1'b1;
        e.dir   = expDir;
        expQ.push_back(e);
    endtask

    task automatic pushCmd(input logic [1:0] op, input logic cDir, input logic [3:0] cnt,
                           input logic [3:0] data, input logic sin);
        obs_t e;
        if (op[1]) begin
            e = '0;
            e.busy = 1'b1;
            e.enb  = 1'b1;
            e.modo = 2'b10;
            e.d    = data;
            e.dir  = cDir;
            expQ.push_back(e);
        end
        if (op != 2'b10) begin
            for (int i = 0; i < int'(cnt); i++) begin
                e = '0;
                e.busy = 1'b1;
                e.enb  = 1'b1;
                e.modo = (op == 2'b01) ? 2'b01 : 2'b00;
                e.dir  = cDir;
                e.sin  = sin;
                expQ.push_back(e);
            end
        end
        e = '0;
        e.busy = 1'b1;
        e.dir  = cDir;
        e.done = 1'b1;
        expQ.push_back(e);
        pushIdle(cDir);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic cDir, input logic [3:0] cnt,
                                 input logic [3:0] data, input logic sin, input logic hold);
        @(negedge clk);
        cmdOp    = op;
        cmdDir   = cDir;
        cmdCnt   = cnt;
        cmdData  = data;
        cmdSin   = sin;
        cmdValid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmdValid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        pushIdle(1'b0);
        pushIdle(1'b0);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            if (n == 0) rst = 1'b0;
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL reset[%0d]: got %b expected %b", n, o, e);
            end
        end
    endtask

    task automatic test_load();
        obs_t o, e;
        applyStimulus(2'b10, 1'b0, 4'd7, 4'b1011, 1'b1, 1'b0);
        pushCmd(2'b10, 1'b0, 4'd7, 4'b1011, 1'b1);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL load[%0d]: got %b expected %b", n, o, e);
            end
        end
        compared++;
        if (regQ !== 4'b1011) begin
            mismatched++;
            $display("[TB] FAIL load_regq: got %b expected 1011", regQ);
        end
    endtask

    task automatic test_load_shift();
        obs_t o, e;
        applyStimulus(2'b11, 1'b1, 4'd3, 4'b1000, 1'b0, 1'b0);
        pushCmd(2'b11, 1'b1, 4'd3, 4'b1000, 1'b0);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL load_shift[%0d]: got %b expected %b", n, o, e);
            end
        end
        compared++;
        if (regQ !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL load_shift_regq: got %b expected 0001", regQ);
        end
    endtask

    task automatic test_zero_steps();
        obs_t o, e;
        applyStimulus(2'b01, 1'b0, 4'd0, 4'b1111, 1'b1, 1'b0);
        pushCmd(2'b01, 1'b0, 4'd0, 4'b1111, 1'b1);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL zero_steps[%0d]: got %b expected %b", n, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        applyStimulus(2'b01, 1'b0, 4'd2, 4'b0000, 1'b0, 1'b1);
        cmdOp  = 2'b01;
        cmdDir = 1'b1;
        cmdCnt = 4'd15;
        pushCmd(2'b01, 1'b0, 4'd2, 4'b0000, 1'b0);
        pushCmd(2'b01, 1'b1, 4'd15, 4'b0000, 1'b0);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL back_to_back[%0d]: got %b expected %b", n, o, e);
            end
            if (n == 3) begin
                @(posedge clk);
                #1 cmdValid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        applyStimulus(2'b00, 1'b1, 4'd5, 4'b0000, 1'b1, 1'b0);
        pushCmd(2'b00, 1'b1, 4'd2, 4'b0000, 1'b1);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        repeat (3) pushIdle(1'b0);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL reset_mid[%0d]: got %b expected %b", n, o, e);
            end
            if (n == 1) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end
    endtask

`ifdef SHIFT_SEQ_ABORT_EN
    task automatic test_abort();
        obs_t o, e;
        applyStimulus(2'b00, 1'b0, 4'd5, 4'b0000, 1'b1, 1'b0);
        pushCmd(2'b00, 1'b0, 4'd2, 4'b0000, 1'b1);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        pushIdle(1'b0);
        pushIdle(1'b0);
        for (int n = 0; expQ.size() > 0; n++) begin
            @(negedge clk);
            o = sample();
            e = expQ.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("[TB] FAIL abort[%0d]: got %b expected %b", n, o, e);
            end
            compared++;
            if (aborted !== (n == 2)) begin
                mismatched++;
                $display("[TB] FAIL aborted_pulse[%0d]: got %b expected %b", n, aborted, (n == 2));
            end
            if (n == 1) begin
                abort = 1'b1;
                #1;
                compared++;
                if (enb !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL abort_enb: got %b expected 0", enb);
                end
                @(posedge clk);
                #1 abort = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        cmdValid   = 1'b0;
        cmdOp      = 2'b00;
        cmdDir     = 1'b0;
        cmdCnt     = 4'd0;
        cmdData    = 4'b0000;
        cmdSin     = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_load();
        test_load_shift();
        test_zero_steps();
        test_back_to_back();
        test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
